// File: rtl/fifo_drain_arbiter_pkg.sv
// Shared definitions for the FIFO drain arbiter: FSM state encoding and counter sizing.
package fifo_drain_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Burst counter covers BURST up to 16 (counts 0..BURST-1).
  localparam int CNT_W = 4;

endpackage

// File: rtl/fifo_drain_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index strictly after last, wrapping to the lowest.
module fifo_drain_arbiter_rr_pick #(
  parameter int NREQ  = 3,
  parameter int SRC_W = 2
) (
  input  logic [NREQ-1:0]  elig_i,
  input  logic [SRC_W-1:0] last_i,
  output logic [SRC_W-1:0] pick_o,
  output logic             any_o
);

  logic [NREQ-1:0] hi_mask;
  logic [NREQ-1:0] hi_elig;

  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      hi_mask[i] = (i > int'(last_i));
    end
    hi_elig = elig_i & hi_mask;

    // Lowest eligible overall is the wrap-around fallback; a candidate above last overrides it.
    pick_o = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (elig_i[i]) pick_o = SRC_W'(i);
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (hi_elig[i]) pick_o = SRC_W'(i);
    end

    any_o = |elig_i;
  end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// Round-robin drain of NREQ source FIFO read ports into one sink FIFO write port, one fixed burst at a time.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  ST_IDLE  | wait for sink room and an eligible source, then pick grant
//  ST_READ  | strobe rd_en on the granted source until the burst is done
//  ST_DRAIN | one cycle to catch the last in-flight word; record last
module fifo_drain_arbiter
  import fifo_drain_arbiter_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int DTA_WIDTH = 64,
  parameter int BURST     = 4,
  parameter int SRC_W     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ*DTA_WIDTH-1:0] src_dout,
  input  logic [NREQ-1:0]           src_valid,
  input  logic [NREQ-1:0]           src_empty,
  input  logic [NREQ-1:0]           src_prog_empty,
  input  logic [NREQ-1:0]           src_underflow,
  output logic [NREQ-1:0]           src_rd_en,
  input  logic                      flush,
  output logic [DTA_WIDTH-1:0]      snk_din,
  output logic                      snk_wr_en,
  output logic [SRC_W-1:0]          snk_src,
  input  logic                      snk_prog_full,
  output logic                      busy,
  output logic                      error
);

  state_e                 state_q;
  logic [SRC_W-1:0]       grant_q;
  logic [SRC_W-1:0]       last_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   busy_q;
  logic                   error_q;
  logic                   wr_en_q;
  logic [DTA_WIDTH-1:0]   din_q;
  logic [SRC_W-1:0]       src_q;

  logic [NREQ-1:0]        elig;
  logic [SRC_W-1:0]       pick;
  logic                   any_elig;
  logic                   strobe;

  assign elig   = flush ? ~src_empty : ~src_prog_empty;
  assign strobe = (state_q == ST_READ) && !src_empty[grant_q];

  always_comb begin
    src_rd_en = '0;
    if (strobe) src_rd_en[grant_q] = 1'b1;
  end

  fifo_drain_arbiter_rr_pick #(
    .NREQ  (NREQ),
    .SRC_W (SRC_W)
  ) u_rr_pick (
    .elig_i (elig),
    .last_i (last_q),
    .pick_o (pick),
    .any_o  (any_elig)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= SRC_W'(NREQ - 1);
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
      wr_en_q <= 1'b0;
      din_q   <= '0;
      src_q   <= '0;
    end else begin
      // Sink path runs every cycle; grant holds through the first IDLE cycle so late valids stay attributed.
      wr_en_q <= src_valid[grant_q];
      din_q   <= src_dout[int'(grant_q)*DTA_WIDTH +: DTA_WIDTH];
      src_q   <= grant_q;
      error_q <= error_q | (src_underflow[grant_q] & busy_q);

      case (state_q)
        ST_IDLE: begin
          if (!snk_prog_full && any_elig) begin
            grant_q <= pick;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_READ;
          end
        end
        ST_READ: begin
          if (strobe) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BURST - 1)) state_q <= ST_DRAIN;
          end else if (flush) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          last_q  <= grant_q;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign snk_wr_en = wr_en_q;
  assign snk_din   = din_q;
  assign snk_src   = src_q;
  assign busy      = busy_q;
  assign error     = error_q;

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Bench for fifo_drain_arbiter: queue-based source FIFO models, per-source scoreboard and a round-robin reference.
module tb_fifo_drain_arbiter;

  localparam int NREQ  = 3;
  localparam int DW    = 64;
  localparam int BURST = 4;
  localparam int SRC_W = 2;

  typedef logic [DW-1:0] word_t;

  logic                 clk;
  logic                 rst;
  logic [NREQ*DW-1:0]   src_dout;
  logic [NREQ-1:0]      src_valid;
  logic [NREQ-1:0]      src_empty;
  logic [NREQ-1:0]      src_prog_empty;
  logic [NREQ-1:0]      src_underflow;
  logic [NREQ-1:0]      src_rd_en;
  logic                 flush;
  logic [DW-1:0]        snk_din;
  logic                 snk_wr_en;
  logic [SRC_W-1:0]     snk_src;
  logic                 snk_prog_full;
  logic                 busy;
  logic                 error;

  fifo_drain_arbiter #(
    .NREQ      (NREQ),
    .DTA_WIDTH (DW),
    .BURST     (BURST),
    .SRC_W     (SRC_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .src_dout       (src_dout),
    .src_valid      (src_valid),
    .src_empty      (src_empty),
    .src_prog_empty (src_prog_empty),
    .src_underflow  (src_underflow),
    .src_rd_en      (src_rd_en),
    .flush          (flush),
    .snk_din        (snk_din),
    .snk_wr_en      (snk_wr_en),
    .snk_src        (snk_src),
    .snk_prog_full  (snk_prog_full),
    .busy           (busy),
    .error          (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int seq      = 0;

  word_t srcq [NREQ][$];
  word_t expq [NREQ][$];
  int    bursts_src[$];
  int    bursts_cyc[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input int s, input int n);
    for (int k = 0; k < n; k++) begin
      word_t w;
      seq++;
      w = {8'(s), 24'(seq), 32'($urandom())};
      srcq[s].push_back(w);
      expq[s].push_back(w);
    end
  endtask

  task automatic clear_queues();
    for (int i = 0; i < NREQ; i++) begin
      srcq[i].delete();
      expq[i].delete();
    end
  endtask

  task automatic do_reset();
    step(1);
    rst = 1'b0;
    clear_queues();
    flush = 1'b0;
    snk_prog_full = 1'b0;
    src_underflow = '0;
    step(3);
    rst = 1'b1;
  endtask

  task automatic wait_rd(input int idx, input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (src_rd_en[idx]) seen = 1'b1;
    end
    chk(name, 64'(seen), 64'd1);
  endtask

  // Expected grant: first eligible index after last, counting modulo NREQ.
  function automatic int rr_ref(input logic [NREQ-1:0] e, input int last);
    int r;
    r = -1;
    for (int k = NREQ; k >= 1; k--) begin
      if (e[(last + k) % NREQ]) r = (last + k) % NREQ;
    end
    return r;
  endfunction

  function automatic int idx_of(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Source FIFO model: rd_en seen at the end of a cycle pops a word that appears with valid next cycle.
  initial begin
    logic [NREQ-1:0] rd_s;
    logic [NREQ-1:0] v;
    forever begin
      @(negedge clk);
      rd_s = src_rd_en;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (rd_s[i] && srcq[i].size() > 0) begin
          v[i] = 1'b1;
          src_dout[i*DW +: DW] = srcq[i].pop_front();
        end else begin
          v[i] = 1'b0;
        end
        src_empty[i]      = (srcq[i].size() == 0);
        src_prog_empty[i] = (srcq[i].size() < BURST);
      end
      src_valid = v;
    end
  end

  // Monitor: exclusivity, latency, data scoreboard and burst-level round-robin check.
  logic [NREQ-1:0] rd_h0, rd_h1, rd_h2;
  logic [NREQ-1:0] eh0, eh1, eh2, eh3;
  bit              pfh0, pfh1, pfh2, pfh3;
  bit              flh0, flh1, flh2, flh3;
  bit              in_burst;
  bit              bflush;
  int              cur_src, blen, last_ref, cyc;

  task automatic close_burst();
    if (bflush) chk("burst_len_flush", 64'((blen >= 1) && (blen <= BURST)), 64'd1);
    else        chk("burst_len", 64'(blen), 64'(BURST));
    in_burst = 1'b0;
  endtask

  initial begin
    cyc = 0;
    in_burst = 1'b0;
    last_ref = NREQ - 1;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        rd_h0 = '0; rd_h1 = '0; rd_h2 = '0;
        eh0 = '0; eh1 = '0; eh2 = '0; eh3 = '0;
        pfh0 = 0; pfh1 = 0; pfh2 = 0; pfh3 = 0;
        flh0 = 0; flh1 = 0; flh2 = 0; flh3 = 0;
        in_burst = 1'b0;
        last_ref = NREQ - 1;
      end else begin
        rd_h2 = rd_h1; rd_h1 = rd_h0; rd_h0 = src_rd_en;
        eh3 = eh2; eh2 = eh1; eh1 = eh0;
        eh0 = flush ? ~src_empty : ~src_prog_empty;
        pfh3 = pfh2; pfh2 = pfh1; pfh1 = pfh0; pfh0 = snk_prog_full;
        flh3 = flh2; flh2 = flh1; flh1 = flh0; flh0 = flush;

        chk("rd_onehot", 64'($countones(src_rd_en) <= 1), 64'd1);
        chk("wr_latency", 64'(snk_wr_en), 64'(|rd_h2));
        if (snk_wr_en && (|rd_h2)) chk("wr_src", 64'(snk_src), 64'(idx_of(rd_h2)));

        if (snk_wr_en) begin
          if (int'(snk_src) >= NREQ) begin
            chk("sb_src_range", 64'(snk_src), 64'd0);
          end else if (expq[snk_src].size() == 0) begin
            chk("sb_unexpected_word", 64'(snk_src), 64'hFF);
          end else begin
            word_t e;
            e = expq[snk_src].pop_front();
            chk("sb_data", snk_din, e);
          end
          if (!in_burst || int'(snk_src) != cur_src) begin
            if (in_burst) close_burst();
            chk("burst_src", 64'(snk_src), 64'(rr_ref(eh3, last_ref)));
            chk("burst_pf_low", 64'(pfh3), 64'd0);
            last_ref = int'(snk_src);
            cur_src  = int'(snk_src);
            bflush   = flh3;
            blen     = 1;
            in_burst = 1'b1;
            bursts_src.push_back(int'(snk_src));
            bursts_cyc.push_back(cyc);
          end else begin
            blen++;
          end
        end else if (in_burst) begin
          close_burst();
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int first_rd, first_wr, rd_n, wr_n;
    logic [23:0] rdv, busyv;
    bit saw_busy, drained;
    int exp2 [6];

    rst = 1'b1;
    flush = 1'b0;
    snk_prog_full = 1'b0;
    src_underflow = '0;
    src_valid = '0;
    src_dout = '0;
    src_empty = '1;
    src_prog_empty = '1;

    // Reset values
    #3 rst = 1'b0;
    #1;
    chk("rst_rd_en", 64'(src_rd_en), 64'd0);
    chk("rst_wr_en", 64'(snk_wr_en), 64'd0);
    chk("rst_din", snk_din, 64'd0);
    chk("rst_src", 64'(snk_src), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    step(3);
    rst = 1'b1;

    // Single source, two full bursts
    push(0, 8);
    first_rd = -1; first_wr = -1; rd_n = 0; wr_n = 0; rdv = '0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      rdv[k] = src_rd_en[0];
      if (src_rd_en[0]) begin rd_n++; if (first_rd < 0) first_rd = k; end
      if (snk_wr_en) begin wr_n++; if (first_wr < 0) first_wr = k; end
    end
    chk("t1_first_rd", 64'(first_rd), 64'd2);
    chk("t1_first_wr", 64'(first_wr), 64'd4);
    chk("t1_rd_pattern", 64'(rdv[11:0]), 64'hF3C);
    chk("t1_rd_count", 64'(rd_n), 64'd8);
    chk("t1_wr_count", 64'(wr_n), 64'd8);

    // All sources eligible: strict rotation, 6 cycles per burst
    do_reset();
    bursts_src.delete();
    bursts_cyc.delete();
    for (int s = 0; s < NREQ; s++) push(s, 8);
    for (int k = 0; k < 80 && bursts_src.size() < 6; k++) @(negedge clk);
    chk("t2_burst_count", 64'(bursts_src.size()), 64'd6);
    exp2 = '{0, 1, 2, 0, 1, 2};
    if (bursts_src.size() >= 6) begin
      for (int k = 0; k < 6; k++) chk("t2_grant_order", 64'(bursts_src[k]), 64'(exp2[k]));
      for (int k = 1; k < 6; k++) chk("t2_spacing", 64'(bursts_cyc[k] - bursts_cyc[k-1]), 64'd6);
    end
    step(4);

    // Sink back-pressure
    do_reset();
    snk_prog_full = 1'b1;
    push(1, 8);
    saw_busy = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (busy || (|src_rd_en)) saw_busy = 1'b1;
    end
    chk("t3_held_idle", 64'(saw_busy), 64'd0);
    step(1);
    snk_prog_full = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t3_start_next_cycle", 64'(src_rd_en), 64'b010);
    step(1);
    snk_prog_full = 1'b1;
    for (int k = 0; k < 12; k++) @(negedge clk);
    chk("t3_burst_completed", 64'(expq[1].size()), 64'd4);
    chk("t3_idle_after", 64'(busy), 64'd0);
    step(1);
    snk_prog_full = 1'b0;
    step(12);
    chk("t3_rest_drained", 64'(expq[1].size()), 64'd0);

    // Flush with a short source
    do_reset();
    flush = 1'b1;
    push(2, 2);
    rdv = '0; busyv = '0; wr_n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      rdv[k] = src_rd_en[2];
      busyv[k] = busy;
      if (snk_wr_en) wr_n++;
    end
    chk("t4_rd_pattern", 64'(rdv[7:0]), 64'h0C);
    chk("t4_busy_pattern", 64'(busyv[7:0]), 64'h3C);
    chk("t4_wr_count", 64'(wr_n), 64'd2);
    chk("t4_idle_end", 64'(busy), 64'd0);
    step(1);
    flush = 1'b0;

    // Underflow: ignored on a non-granted source, sticky on the granted one
    do_reset();
    push(0, 8);
    push(1, 8);
    wait_rd(0, 40, "t5_wait_src0");
    step(1);
    src_underflow = 3'b100;
    step(1);
    src_underflow = '0;
    step(2);
    chk("t5_error_nongranted", 64'(error), 64'd0);
    wait_rd(1, 40, "t5_wait_src1");
    step(1);
    src_underflow = 3'b010;
    step(1);
    src_underflow = '0;
    @(negedge clk);
    chk("t5_error_set", 64'(error), 64'd1);
    step(10);
    chk("t5_error_sticky", 64'(error), 64'd1);
    step(1);
    rst = 1'b0;
    #1;
    chk("t5_error_cleared", 64'(error), 64'd0);
    step(2);
    rst = 1'b1;

    // Reset in the middle of a burst
    do_reset();
    push(0, 4);
    push(1, 8);
    wait_rd(1, 60, "t6_wait_src1");
    step(1);
    rst = 1'b0;
    clear_queues();
    #1;
    chk("t6_rd_en_cleared", 64'(src_rd_en), 64'd0);
    chk("t6_wr_en_cleared", 64'(snk_wr_en), 64'd0);
    chk("t6_busy_cleared", 64'(busy), 64'd0);
    step(3);
    rst = 1'b1;
    bursts_src.delete();
    bursts_cyc.delete();
    for (int s = 0; s < NREQ; s++) push(s, 4);
    for (int k = 0; k < 40 && bursts_src.size() < 1; k++) @(negedge clk);
    chk("t6_first_burst_seen", 64'(bursts_src.size() >= 1), 64'd1);
    if (bursts_src.size() >= 1) chk("t6_first_grant", 64'(bursts_src[0]), 64'd0);
    step(20);

    // Randomized traffic with back-pressure, then flush drain
    do_reset();
    for (int k = 0; k < 800; k++) begin
      step(1);
      if ($urandom_range(99) < 35) push(int'($urandom_range(NREQ - 1)), 1);
      if ($urandom_range(99) < 2) snk_prog_full = ~snk_prog_full;
    end
    snk_prog_full = 1'b0;
    flush = 1'b1;
    for (int k = 0; k < 200; k++) begin
      step(1);
      if ($urandom_range(99) < 15) push(int'($urandom_range(NREQ - 1)), 1);
    end
    drained = 1'b0;
    for (int k = 0; k < 1500 && !drained; k++) begin
      @(negedge clk);
      drained = !busy && (expq[0].size() == 0) && (expq[1].size() == 0) && (expq[2].size() == 0);
    end
    chk("rand_drained", 64'(drained), 64'd1);
    for (int s = 0; s < NREQ; s++) chk("rand_src_empty", 64'(srcq[s].size()), 64'd0);
    chk("rand_error_clear", 64'(error), 64'd0);
    step(1);
    flush = 1'b0;
    step(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
